// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and the matching receiver.
// The frame state set and the idle line level live here so both ends agree.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } serial_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter: o_tick marks the last clock cycle of each serial bit.
// i_restart zeroes the count so every state starts on a fresh bit period.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || o_tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// LSB-first serial transmitter: start bit, DATA_WIDTH data bits, stop bit.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit between data and stop.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    serial_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  restart;
    logic                  accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Holding the timer in restart while idle aligns bit periods to the START entry.
    assign restart = (state_q == IDLE);
    assign accept  = i_valid && ready_q;
    assign shifted = shreg_q >> 1;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(restart),
        .o_tick   (tick)
    );

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (accept) begin
                    state_d  = START;
                    shreg_d  = i_data;
                    idx_d    = '0;
                    tx_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shifted;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = LINE_IDLE;
`endif
                    end else begin
                        tx_d = shifted[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = LINE_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= LINE_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = ~ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frame tables at CLKS_PER_BIT=4 plus a
// CLKS_PER_BIT=1 instance; follows SERIAL_TX_PARITY_EN when it is defined.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 2 + DW + PAR;
    localparam int FL    = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic [0:7] lsb_first;  // data bits in line order, hand-written
        logic       par;        // hand-computed even parity
    } vec_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data, data1;
    logic          valid, valid1;
    logic          ready, tx, busy, done;
    logic          ready1, tx1, busy1, done1;

    int n_tests;
    int n_fail;

    vec_t vecs [6];

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data),
        .i_valid(valid),
        .o_ready(ready),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data1),
        .i_valid(valid1),
        .o_ready(ready1),
        .o_tx   (tx1),
        .o_busy (busy1),
        .o_done (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return v.lsb_first[b-1];
        if (PAR == 1 && b == DW + 1) return v.par;
        return 1'b1;
    endfunction

    task automatic start(input vec_t v);
        data  = v.data;
        valid = 1'b1;
        step();
    endtask

    // Called in frame cycle 0; returns in the o_done cycle with inputs for it set.
    task automatic run_frame(input vec_t v, input string tag, input int vfrom,
                             input int vto, input logic [7:0] vdata);
        for (int c = 0; c <= FL; c++) begin
            if (c < FL)
                check($sformatf("%s c%0d tx/busy/ready/done", tag, c),
                      {tx, busy, ready, done}, {exp_bit(v, c / CPB), 1'b1, 1'b0, 1'b0});
            else
                check($sformatf("%s end tx/busy/ready/done", tag),
                      {tx, busy, ready, done}, 4'b1011);
            valid = (c >= vfrom && c <= vto);
            if (valid) data = vdata;
            if (c < FL) step();
        end
    endtask

    initial begin
        vec_t v1;
        int   done_cnt;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{8'h3C, 8'b00111100, 1'b0};
        vecs[2] = '{8'hC3, 8'b11000011, 1'b0};
        vecs[3] = '{8'h07, 8'b11100000, 1'b1};
        vecs[4] = '{8'h00, 8'b00000000, 1'b0};
        vecs[5] = '{8'hFF, 8'b11111111, 1'b0};

        rst = 1'b1; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
        step();
        step();
        check("reset tx/ready/busy/done", {tx, ready, busy, done}, 4'b1100);
        check("reset1 tx/ready/busy/done", {tx1, ready1, busy1, done1}, 4'b1100);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            start(vecs[i]);
            run_frame(vecs[i], $sformatf("vec%0d", i), -1, -2, 8'h00);
            step();
            check($sformatf("vec%0d done one-shot", i), {tx, ready, done}, 3'b110);
        end

        // Back-to-back: valid held high, second word sits on i_data during frame 1.
        start(vecs[1]);
        run_frame(vecs[1], "b2b first", 0, FL, vecs[2].data);
        step();
        run_frame(vecs[2], "b2b second", -1, -2, 8'h00);
        step();
        check("b2b after second", {tx, ready, done}, 3'b110);

        // Word offered while busy must neither corrupt nor queue.
        start(vecs[0]);
        run_frame(vecs[0], "busy ignore", 2, FL - 1, 8'hFF);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (busy || !tx || done) done_cnt++;
        end
        check("busy ignore no queued frame", done_cnt, 0);

        // Reset at cycle 10 of a frame.
        start(vecs[0]);
        valid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("pre-reset mid frame busy", {tx, busy}, {exp_bit(vecs[0], 10 / CPB), 1'b1});
        rst = 1'b1;
        step();
        check("abort tx/ready/busy/done", {tx, ready, busy, done}, 4'b1100);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < FL + 8; c++) begin
            step();
            if (done || !tx || busy) done_cnt++;
        end
        check("abort no done and line idle", done_cnt, 0);

        // Reset wins over acceptance.
        data = 8'hA5; valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; valid = 1'b0;
        check("reset priority tx/ready/busy", {tx, ready, busy}, 3'b110);
        step();
        check("reset priority stays idle", {tx, ready, busy}, 3'b110);

        // CLKS_PER_BIT=1 instance with 0x01.
        v1 = '{8'h01, 8'b10000000, 1'b1};
        data1 = v1.data; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        for (int c = 0; c < NBITS; c++) begin
            check($sformatf("cpb1 c%0d tx/busy/done", c), {tx1, busy1, done1},
                  {exp_bit(v1, c), 1'b1, 1'b0});
            step();
        end
        check("cpb1 end tx/ready/done", {tx1, ready1, done1}, 3'b111);
        step();
        check("cpb1 done one-shot", {tx1, ready1, done1}, 3'b110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
